// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: op encoding and FSM states.
package usr_pkg;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_SHL   = 3'd1,
    OP_SHR   = 3'd2,
    OP_ROL   = 3'd3,
    OP_ROR   = 3'd4,
    OP_ASR   = 3'd5,
    OP_LOAD  = 3'd6,
    OP_CLEAR = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift_op(input op_e o);
    return (o != OP_HOLD) && (o != OP_LOAD) && (o != OP_CLEAR);
  endfunction

endpackage

// File: rtl/usr_next_value.sv
// Single-step shift/rotate datapath, shared by the accept edge and burst edges.
module usr_next_value
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  op_e              op_i,
  input  logic             serial_in_i,
  output logic [WIDTH-1:0] next_q_o,
  output logic             next_shift_out_o
);

  always_comb begin
    next_q_o         = q_i;
    next_shift_out_o = 1'b0;
    unique case (op_i)
      OP_SHL: begin
        next_q_o         = {q_i[WIDTH-2:0], serial_in_i};
        next_shift_out_o = q_i[WIDTH-1];
      end
      OP_SHR: begin
        next_q_o         = {serial_in_i, q_i[WIDTH-1:1]};
        next_shift_out_o = q_i[0];
      end
      OP_ROL: begin
        next_q_o         = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        next_shift_out_o = q_i[WIDTH-1];
      end
      OP_ROR: begin
        next_q_o         = {q_i[0], q_i[WIDTH-1:1]};
        next_shift_out_o = q_i[0];
      end
      OP_ASR: begin
        next_q_o         = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
        next_shift_out_o = q_i[0];
      end
      default: begin
        next_q_o         = q_i;
        next_shift_out_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register with single-cycle load/clear and multi-cycle shift bursts.
// The first shift lands on the accepting edge; remaining shifts run in SHIFT state.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [CW-1:0]    burst_len,
  input  logic [WIDTH-1:0] load_data,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             shift_out,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CW-1:0]    remaining_q, remaining_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             shift_out_q, shift_out_d;
  logic             done_q, done_d;

  op_e              op_in;
  op_e              step_op;
  logic [WIDTH-1:0] step_q;
  logic             step_shift_out;

  assign op_in   = op_e'(op);
  assign step_op = (state_q == ST_SHIFT) ? op_q : op_in;

  usr_next_value #(.WIDTH(WIDTH)) u_next (
    .q_i              (q_q),
    .op_i             (step_op),
    .serial_in_i      (serial_in),
    .next_q_o         (step_q),
    .next_shift_out_o (step_shift_out)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_HOLD;
      remaining_q <= '0;
      q_q         <= '0;
      shift_out_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      remaining_q <= remaining_d;
      q_q         <= q_d;
      shift_out_q <= shift_out_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    remaining_d = remaining_q;
    q_d         = q_q;
    shift_out_d = shift_out_q;
    done_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          if (is_shift_op(op_in)) begin
            q_d         = step_q;
            shift_out_d = step_shift_out;
            op_d        = op_in;
            // burst_len 0 and 1 both mean a single shift
            if (burst_len <= CW'(1)) begin
              done_d = 1'b1;
            end else begin
              state_d     = ST_SHIFT;
              remaining_d = burst_len - CW'(1);
            end
          end else if (op_in == OP_LOAD) begin
            q_d    = load_data;
            done_d = 1'b1;
          end else if (op_in == OP_CLEAR) begin
            q_d    = '0;
            done_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        q_d         = step_q;
        shift_out_d = step_shift_out;
        remaining_d = remaining_q - CW'(1);
        if (remaining_q == CW'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_SHIFT);
  end

  assign q         = q_q;
  assign shift_out = shift_out_q;
  assign done      = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed-vector bench with an arithmetic reference model checked every cycle.
module tb_universal_shift_register;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          op_valid;
  logic [2:0]    op;
  logic [CW-1:0] burst_len;
  logic [W-1:0]  load_data;
  logic          serial_in;
  logic [W-1:0]  q;
  logic          shift_out;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  universal_shift_register #(.WIDTH(W), .CW(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op_valid  (op_valid),
    .op        (op),
    .burst_len (burst_len),
    .load_data (load_data),
    .serial_in (serial_in),
    .q         (q),
    .shift_out (shift_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference model: values as plain integers, one shift computed arithmetically.
  logic [W-1:0] m_q;
  logic         m_so, m_busy, m_done;
  int           m_rem, m_op;
  bit           model_valid = 0;

  function automatic logic [8:0] shift1(input int o, input logic [7:0] v8, input logic si);
    int v, nv, so;
    v  = int'(v8);
    nv = v;
    so = 0;
    case (o)
      1: begin nv = (v * 2 + int'(si)) % 256;        so = (v >= 128) ? 1 : 0; end
      2: begin nv = v / 2 + (si ? 128 : 0);          so = v % 2; end
      3: begin nv = (v * 2) % 256 + v / 128;         so = (v >= 128) ? 1 : 0; end
      4: begin nv = v / 2 + (v % 2) * 128;           so = v % 2; end
      5: begin nv = v / 2 + ((v >= 128) ? 128 : 0);  so = v % 2; end
      default: ;
    endcase
    return {so[0], nv[7:0]};
  endfunction

  always @(posedge clk) begin
    logic [8:0] r;
    if (!reset_n) begin
      m_q = '0; m_so = 0; m_busy = 0; m_done = 0; m_rem = 0; m_op = 0;
      model_valid = 1;
    end else if (model_valid) begin
      m_done = 0;
      if (m_busy) begin
        r = shift1(m_op, m_q, serial_in);
        m_q = r[7:0]; m_so = r[8];
        m_rem = m_rem - 1;
        if (m_rem == 0) begin m_busy = 0; m_done = 1; end
      end else if (op_valid) begin
        if (op == 3'd6) begin m_q = load_data; m_done = 1; end
        else if (op == 3'd7) begin m_q = '0; m_done = 1; end
        else if (op != 3'd0) begin
          r = shift1(int'(op), m_q, serial_in);
          m_q = r[7:0]; m_so = r[8];
          if (int'(burst_len) <= 1) m_done = 1;
          else begin m_busy = 1; m_rem = int'(burst_len) - 1; m_op = int'(op); end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%02h, expected 0x%02h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      chk("cyc_q", q, m_q);
      chk("cyc_shift_out", {7'd0, shift_out}, {7'd0, m_so});
      chk("cyc_busy", {7'd0, busy}, {7'd0, m_busy});
      chk("cyc_done", {7'd0, done}, {7'd0, m_done});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for exactly one edge; returns #1 after that edge.
  task automatic do_op(input logic [2:0] o, input int bl, input logic [7:0] ld, input logic si);
    op_valid  = 1'b1;
    op        = o;
    burst_len = CW'(bl);
    load_data = ld;
    serial_in = si;
    tick();
    op_valid = 1'b0;
    $display("op=%0d burst=%0d load=0x%02h si=%0d -> q=0x%02h so=%0d busy=%0d done=%0d",
             o, bl, ld, si, q, shift_out, busy, done);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles, expected 0", busy, n);
    end
  endtask

  initial begin
    reset_n = 1'b0; op_valid = 1'b1; op = 3'd6; burst_len = '0;
    load_data = 8'hFF; serial_in = 1'b0;
    tick();
    chk("reset_q", q, 8'h00);
    chk("reset_busy", {7'd0, busy}, 8'h00);
    chk("reset_done", {7'd0, done}, 8'h00);
    reset_n = 1'b1; op_valid = 1'b0;
    tick();

    do_op(3'd6, 0, 8'hA5, 1'b0);
    chk("load_a5", q, 8'hA5);
    chk("load_done", {7'd0, done}, 8'h01);
    do_op(3'd1, 1, 8'h00, 1'b1);
    chk("shl_q", q, 8'h4B);
    chk("shl_so", {7'd0, shift_out}, 8'h01);
    do_op(3'd0, 3, 8'h00, 1'b0);
    chk("hold_q", q, 8'h4B);
    chk("hold_done", {7'd0, done}, 8'h00);

    do_op(3'd6, 0, 8'h81, 1'b0);
    do_op(3'd4, 3, 8'h00, 1'b0);
    chk("ror_1", q, 8'hC0);
    chk("ror_busy", {7'd0, busy}, 8'h01);
    tick();
    chk("ror_2", q, 8'h60);
    tick();
    chk("ror_3", q, 8'h30);
    chk("ror_so", {7'd0, shift_out}, 8'h00);
    chk("ror_done", {7'd0, done}, 8'h01);

    do_op(3'd6, 0, 8'h90, 1'b0);
    do_op(3'd5, 2, 8'h00, 1'b0);
    chk("asr_1", q, 8'hC8);
    do_op(3'd6, 0, 8'hFF, 1'b0);
    chk("asr_2", q, 8'hE4);
    chk("asr_so", {7'd0, shift_out}, 8'h00);
    chk("asr_done", {7'd0, done}, 8'h01);

    do_op(3'd6, 0, 8'h01, 1'b0);
    do_op(3'd2, 0, 8'h00, 1'b0);
    chk("shr0_q", q, 8'h00);
    chk("shr0_so", {7'd0, shift_out}, 8'h01);
    chk("shr0_busy", {7'd0, busy}, 8'h00);

    // burst longer than the register: rotate wraps
    do_op(3'd6, 0, 8'h81, 1'b0);
    do_op(3'd3, 9, 8'h00, 1'b0);
    wait_idle();
    chk("rol9_q", q, 8'h03);
    chk("rol9_done", {7'd0, done}, 8'h01);

    // serial_in is resampled on every burst edge
    do_op(3'd7, 0, 8'h00, 1'b0);
    chk("clear_q", q, 8'h00);
    do_op(3'd1, 3, 8'h00, 1'b1);
    serial_in = 1'b0;
    tick();
    serial_in = 1'b1;
    tick();
    chk("shl3_q", q, 8'h05);

    do_op(3'd6, 0, 8'h81, 1'b0);
    do_op(3'd3, 5, 8'h00, 1'b0);
    tick();
    chk("rol_abort_pre", q, 8'h06);
    reset_n = 1'b0;
    tick();
    chk("abort_q", q, 8'h00);
    chk("abort_busy", {7'd0, busy}, 8'h00);
    chk("abort_done", {7'd0, done}, 8'h00);
    reset_n = 1'b1;
    tick();
    chk("abort_no_done", {7'd0, done}, 8'h00);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
